// File: rtl/dcache_setassoc_pkg.sv
// Shared types and width helpers for the set-associative data cache.
// Field widths are derived from the address width, block size and set count.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        REFILL    = 2'd3
    } state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_WPB    = 4;
    localparam int DEF_SETS   = 4;
    localparam int DEF_WAYS   = 2;
    localparam int DEF_CNT_W  = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int off_bits(input int wpb);
        return clog2(wpb);
    endfunction

    function automatic int idx_bits(input int sets);
        return clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int wpb, input int sets);
        return addr_w - clog2(wpb) - clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_setassoc_lru.sv
// Per-set LRU age tracking: the accessed way becomes youngest, younger ways age by one,
// and the way holding the oldest age (WAYS-1) is offered as the replacement victim.
module dcache_lru #(
    parameter int SETS  = 4,
    parameter int WAYS  = 2,
    parameter int IDX_W = 2,
    parameter int WAY_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] set_idx_i,
    input  logic [WAY_W-1:0] access_way_i,
    input  logic             update_i,
    output logic [WAY_W-1:0] victim_way_o
);

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] acc_age;

    assign acc_age = age_q[set_idx_i][access_way_i];

    // NOTE: non-blocking assignments, so every comparison below sees the pre-edge ages.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (update_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == access_way_i) begin
                    age_q[set_idx_i][w] <= '0;
                end else if (age_q[set_idx_i][w] < acc_age) begin
                    age_q[set_idx_i][w] <= age_q[set_idx_i][w] + 1'b1;
                end
            end
        end
    end

    // NOTE: default assignment first, so no latch is inferred when no way matches.
    always_comb begin
        victim_way_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[set_idx_i][w] == WAY_W'(WAYS - 1)) victim_way_o = WAY_W'(w);
        end
    end

endmodule

// File: rtl/dcache_setassoc.sv
// N-way set-associative write-back, write-allocate data cache with LRU replacement
// and saturating hit/miss counters.
module dcache_setassoc
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WPB    = DEF_WPB,
    parameter int SETS   = DEF_SETS,
    parameter int WAYS   = DEF_WAYS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_read,
    input  logic                         cpu_write,
    input  logic [ADDR_W-1:0]            cpu_address,
    input  logic [DATA_W-1:0]            cpu_writedata,
    output logic [DATA_W-1:0]            cpu_readdata,
    output logic                         cpu_busywait,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [ADDR_W-clog2(WPB)-1:0] mem_address,
    output logic [DATA_W*WPB-1:0]        mem_writedata,
    input  logic [DATA_W*WPB-1:0]        mem_readdata,
    input  logic                         mem_busywait,
    output logic [CNT_W-1:0]             hit_count,
    output logic [CNT_W-1:0]             miss_count
);

    localparam int OFF_W    = off_bits(WPB);
    localparam int IDX_BITS = idx_bits(SETS);
    localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int TAG_W    = tag_bits(ADDR_W, WPB, SETS);
    localparam int WAY_W    = (WAYS > 1) ? clog2(WAYS) : 1;
    localparam int MEM_AW   = ADDR_W - OFF_W;
    localparam int BLK_W    = DATA_W * WPB;

    function automatic logic [MEM_AW-1:0] blk_addr(input logic [TAG_W-1:0] t,
                                                   input logic [IDX_W-1:0] i);
        return (MEM_AW'(t) << IDX_BITS) | MEM_AW'(i);
    endfunction

    logic [OFF_W-1:0]  offset;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    assign offset = cpu_address[OFF_W-1:0];
    assign tag    = cpu_address[ADDR_W-1 -: TAG_W];

    generate
        if (IDX_BITS > 0) begin : g_idx
            assign idx = cpu_address[OFF_W +: IDX_BITS];
        end else begin : g_idx_single
            assign idx = '0;
        end
    endgenerate

    // NOTE: data and tag arrays are deliberately not reset; valid bits gate every use.
    logic [DATA_W-1:0] data_q  [SETS][WAYS][WPB];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];

    state_e            state_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [TAG_W-1:0]  req_tag_q;
    logic [WAY_W-1:0]  victim_q;
    logic [BLK_W-1:0]  fill_q;
    logic              mem_read_q, mem_write_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [BLK_W-1:0]  mem_wdata_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

    logic              req, hit, found_inv, victim_dirty, write_hit, refill;
    logic [WAY_W-1:0]  hit_way, victim_way, lru_way, lru_access;
    logic [IDX_W-1:0]  lru_set;
    logic [BLK_W-1:0]  victim_blk;

    assign req       = cpu_read | cpu_write;
    assign refill    = (state_q == REFILL);
    assign write_hit = (state_q == IDLE) && cpu_write && hit;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Invalid ways are filled lowest-index first before any valid line is displaced.
    always_comb begin
        victim_way = lru_way;
        found_inv  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_inv && !valid_q[idx][w]) begin
                victim_way = WAY_W'(w);
                found_inv  = 1'b1;
            end
        end
    end

    assign victim_dirty = valid_q[idx][victim_way] && dirty_q[idx][victim_way];

    always_comb begin
        victim_blk = '0;
        for (int i = 0; i < WPB; i++) begin
            victim_blk[i*DATA_W +: DATA_W] = data_q[idx][victim_way][i];
        end
    end

    assign lru_set    = refill ? req_idx_q : idx;
    assign lru_access = refill ? victim_q  : hit_way;

    dcache_lru #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .clk          (clk),
        .reset        (reset),
        .set_idx_i    (lru_set),
        .access_way_i (lru_access),
        .update_i     (refill || ((state_q == IDLE) && req && hit)),
        .victim_way_o (lru_way)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_idx_q   <= '0;
            req_tag_q   <= '0;
            victim_q    <= '0;
            fill_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
                    end else if (req) begin
                        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
                        req_idx_q <= idx;
                        req_tag_q <= tag;
                        victim_q  <= victim_way;
                        if (victim_dirty) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= blk_addr(tag_q[idx][victim_way], idx);
                            mem_wdata_q <= victim_blk;
                        end else begin
                            state_q    <= FETCH;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= blk_addr(tag, idx);
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state_q     <= FETCH;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= blk_addr(req_tag_q, req_idx_q);
                    end
                end
                FETCH: begin
                    if (!mem_busywait) begin
                        state_q    <= REFILL;
                        mem_read_q <= 1'b0;
                        fill_q     <= mem_readdata;
                    end
                end
                REFILL:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (refill) begin
            tag_q[req_idx_q][victim_q] <= req_tag_q;
            for (int i = 0; i < WPB; i++) begin
                data_q[req_idx_q][victim_q][i] <= fill_q[i*DATA_W +: DATA_W];
            end
        end else if (write_hit) begin
            data_q[idx][hit_way][offset] <= cpu_writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else if (refill) begin
            valid_q[req_idx_q][victim_q] <= 1'b1;
            dirty_q[req_idx_q][victim_q] <= 1'b0;
        end else if (write_hit) begin
            dirty_q[idx][hit_way] <= 1'b1;
        end
    end

    assign cpu_busywait  = (state_q != IDLE) || (req && !hit);
    assign cpu_readdata  = hit ? data_q[idx][hit_way][offset] : '0;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_addr_q;
    assign mem_writedata = mem_wdata_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

endmodule
